// File: rtl/frame_cfg_pkg.sv
// Shared definitions for the column frame writer: header layout and FSM states.
package frame_cfg_pkg;

    localparam logic [15:0] HDR_MAGIC     = 16'hFAB0;
    localparam int          HDR_MAGIC_MSB = 31;
    localparam int          HDR_MAGIC_LSB = 16;
    localparam int          HDR_IDX_MSB   = 7;
    localparam int          HDR_IDX_LSB   = 0;
    localparam int          HDR_IDX_W     = HDR_IDX_MSB - HDR_IDX_LSB + 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DROP,
        ST_STROBE,
        ST_HOLD
    } state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/frame_data_shifter.sv
// Row shift register: each enabled word enters the low slice and older words move up.
module frame_data_shifter #(
    parameter int RowW    = 32,
    parameter int NumRows = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      shift_en,
    input  logic [RowW-1:0]           din,
    output logic [NumRows*RowW-1:0]   dout
);

    logic [NumRows*RowW-1:0] data_q;
    logic [NumRows*RowW-1:0] data_d;
    logic [NumRows*RowW-1:0] shifted;

    generate
        if (NumRows > 1) begin : g_multi
            assign shifted = {data_q[(NumRows-1)*RowW-1:0], din};
        end else begin : g_single
            assign shifted = din;
        end
    endgenerate

    always_comb begin
        data_d = data_q;
        if (shift_en) begin
            data_d = shifted;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign dout = data_q;

endmodule

// File: rtl/frame_write_ctrl.sv
// Parses header-framed configuration words, assembles a column frame and issues
// a single one-hot write strobe for it.
module frame_write_ctrl
    import frame_cfg_pkg::*;
#(
    parameter int MaxFramesPerCol = 32,
    parameter int FrameBitsPerRow = 32,
    parameter int NumRows         = 2
) (
    input  logic                                 CLK,
    input  logic                                 reset,
    input  logic [FrameBitsPerRow-1:0]           in_data,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
    output logic [MaxFramesPerCol-1:0]           FrameStrobe,
    output logic                                 busy,
    output logic                                 err,
    output logic [15:0]                          frames_written
);

    localparam int RowCntW = (NumRows > 1) ? $clog2(NumRows) : 1;
    localparam int IdxW    = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
    localparam logic [RowCntW-1:0] LastRow = RowCntW'(NumRows - 1);

    state_e               state_q, state_d;
    logic [RowCntW-1:0]   row_q, row_d;
    logic [IdxW-1:0]      idx_q, idx_d;
    logic                 err_q, err_d;
    logic [15:0]          cnt_q, cnt_d;

    logic                 accept;
    logic                 shift_en;
    logic                 hdr_hit;
    logic [HDR_IDX_W-1:0] hdr_idx;
    logic                 idx_ok;
    logic [MaxFramesPerCol-1:0] strobe;

    assign hdr_hit = (in_data[HDR_MAGIC_MSB:HDR_MAGIC_LSB] == HDR_MAGIC);
    assign hdr_idx = in_data[HDR_IDX_MSB:HDR_IDX_LSB];
    assign idx_ok  = ({{(32-HDR_IDX_W){1'b0}}, hdr_idx} < 32'(MaxFramesPerCol));
    assign accept  = in_valid && in_ready;

    always_comb begin
        in_ready = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_DROP);
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        idx_d    = idx_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        shift_en = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && hdr_hit) begin
                    row_d = '0;
                    if (idx_ok) begin
                        idx_d   = hdr_idx[IdxW-1:0];
                        state_d = ST_LOAD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DROP;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    shift_en = 1'b1;
                    if (row_q == LastRow) begin
                        row_d   = '0;
                        state_d = ST_STROBE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            // Dropped frames still consume their payload so the stream stays aligned.
            ST_DROP: begin
                if (accept) begin
                    if (row_q == LastRow) begin
                        row_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        row_d = row_q + 1'b1;
                    end
                end
            end
            ST_STROBE: begin
                cnt_d   = sat_inc16(cnt_q);
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Strobe is decoded from the state register so reset removes it on the next edge.
    always_comb begin
        strobe = '0;
        if (state_q == ST_STROBE) begin
            strobe[idx_q] = 1'b1;
        end
    end

    frame_data_shifter #(
        .RowW    (FrameBitsPerRow),
        .NumRows (NumRows)
    ) u_shifter (
        .clk      (CLK),
        .rst      (reset),
        .shift_en (shift_en),
        .din      (in_data),
        .dout     (FrameData)
    );

    assign FrameStrobe    = strobe;
    assign busy           = (state_q != ST_IDLE);
    assign err            = err_q;
    assign frames_written = cnt_q;

endmodule

// File: tb/tb_frame_write_ctrl.sv
// Bench for frame_write_ctrl: directed scenarios plus a randomized stream checked
// against a word-stream parsing model.
module tb_frame_write_ctrl;

    logic        CLK = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] FrameData;
    logic [31:0] FrameStrobe;
    logic        busy;
    logic        err;
    logic [15:0] frames_written;

    frame_write_ctrl dut (
        .CLK            (CLK),
        .reset          (reset),
        .in_data        (in_data),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .FrameData      (FrameData),
        .FrameStrobe    (FrameStrobe),
        .busy           (busy),
        .err            (err),
        .frames_written (frames_written)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    logic [31:0] obs_s[$];
    logic [63:0] obs_d[$];
    int          obs_c[$];
    logic [63:0] hold_d[$];
    int          rdy_low = 0;
    bit          prev_strobe = 1'b0;

    always @(negedge CLK) begin
        if (prev_strobe) hold_d.push_back(FrameData);
        prev_strobe = (FrameStrobe != 32'h0);
        if (FrameStrobe != 32'h0) begin
            obs_s.push_back(FrameStrobe);
            obs_d.push_back(FrameData);
            obs_c.push_back(cyc);
        end
        if (!in_ready && !reset) rdy_low++;
    end

    // Reference model state: the stream of accepted words and what it implies.
    logic [31:0] stim_q[$];
    logic [31:0] exp_s[$];
    logic [63:0] exp_d[$];
    logic [63:0] m_data;
    logic        m_err;
    int          m_frames;

    task automatic model_run();
        int i = 0;
        logic [31:0] w;
        int idx;
        while (i < stim_q.size()) begin
            w = stim_q[i];
            i++;
            if (w[31:16] == 16'hFAB0 && i + 2 <= stim_q.size()) begin
                idx = int'(w[7:0]);
                if (idx < 32) begin
                    m_data = {stim_q[i], stim_q[i+1]};
                    exp_s.push_back(32'h1 << idx);
                    exp_d.push_back(m_data);
                    m_frames = (m_frames < 65535) ? m_frames + 1 : 65535;
                end else begin
                    m_err = 1'b1;
                end
                i += 2;
            end
        end
    endtask

    task automatic clear_mon();
        obs_s.delete();
        obs_d.delete();
        obs_c.delete();
        hold_d.delete();
        rdy_low = 0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 32'h0;
        repeat (2) @(posedge CLK);
        #1 reset = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send_word(input logic [31:0] d, output int acc);
        bit got = 1'b0;
        bit rdy;
        in_data  = d;
        in_valid = 1'b1;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge CLK);
            rdy = in_ready;
            @(posedge CLK);
            #1;
            if (rdy) got = 1'b1;
        end
        acc = cyc;
        if (!got) begin
            n_checks++;
            $display("FAIL send_timeout: word %h not accepted within 50 cycles", d);
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        in_valid = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(posedge CLK);
            #1;
            if (!busy) ok = 1'b1;
        end
        if (!ok) begin
            n_checks++;
            $display("FAIL idle_timeout: busy=%b still set after 20 cycles", busy);
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (FrameData !== 64'h0) $display("FAIL rst_data: got %h want 0", FrameData); else n_pass++;
        n_checks++; if (FrameStrobe !== 32'h0) $display("FAIL rst_strobe: got %h want 0", FrameStrobe); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL rst_err: got %b want 0", err); else n_pass++;
        n_checks++; if (frames_written !== 16'h0) $display("FAIL rst_count: got %h want 0", frames_written); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", in_ready); else n_pass++;
    endtask

    task automatic test_basic();
        int a;
        clear_mon();
        send_word(32'hFAB00005, a);
        send_word(32'h11111111, a);
        send_word(32'h22222222, a);
        wait_idle();
        n_checks++; if (obs_s.size() !== 1) $display("FAIL basic_nstrobe: got %0d want 1", obs_s.size()); else n_pass++;
        if (obs_s.size() > 0) begin
            n_checks++; if (obs_s[0] !== 32'h00000020) $display("FAIL basic_strobe: got %h want 00000020", obs_s[0]); else n_pass++;
            n_checks++; if (obs_d[0] !== 64'h11111111_22222222) $display("FAIL basic_data: got %h want 1111111122222222", obs_d[0]); else n_pass++;
        end
        if (hold_d.size() > 0) begin
            n_checks++; if (hold_d[0] !== 64'h11111111_22222222) $display("FAIL basic_hold: got %h want 1111111122222222", hold_d[0]); else n_pass++;
        end
        n_checks++; if (frames_written !== 16'd1) $display("FAIL basic_count: got %0d want 1", frames_written); else n_pass++;
        n_checks++; if (rdy_low !== 2) $display("FAIL basic_ready_low: got %0d want 2", rdy_low); else n_pass++;
    endtask

    task automatic test_junk();
        int a;
        clear_mon();
        send_word(32'h12345678, a);
        idle(1);
        n_checks++; if (busy !== 1'b0) $display("FAIL junk_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL junk_err: got %b want 0", err); else n_pass++;
        n_checks++; if (FrameData !== 64'h11111111_22222222) $display("FAIL junk_data: got %h want 1111111122222222", FrameData); else n_pass++;
        n_checks++; if (obs_s.size() !== 0) $display("FAIL junk_strobe: got %0d strobes want 0", obs_s.size()); else n_pass++;
    endtask

    task automatic test_stall();
        int a;
        clear_mon();
        send_word(32'hFAB00009, a);
        send_word(32'hA5A5A5A5, a);
        idle(5);
        n_checks++; if (obs_s.size() !== 0) $display("FAIL stall_early: got %0d strobes want 0", obs_s.size()); else n_pass++;
        send_word(32'h5A5A5A5A, a);
        wait_idle();
        n_checks++; if (obs_s.size() !== 1) $display("FAIL stall_nstrobe: got %0d want 1", obs_s.size()); else n_pass++;
        if (obs_s.size() > 0) begin
            n_checks++; if (obs_c[0] !== a) $display("FAIL stall_timing: strobe cycle %0d want %0d", obs_c[0], a); else n_pass++;
            n_checks++; if (obs_s[0] !== 32'h00000200) $display("FAIL stall_strobe: got %h want 00000200", obs_s[0]); else n_pass++;
            n_checks++; if (obs_d[0] !== 64'hA5A5A5A5_5A5A5A5A) $display("FAIL stall_data: got %h want a5a5a5a55a5a5a5a", obs_d[0]); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int a;
        clear_mon();
        send_word(32'hFAB00000, a);
        send_word(32'hCAFE0001, a);
        send_word(32'hCAFE0002, a);
        send_word(32'hFAB0001F, a);
        send_word(32'hBEEF0003, a);
        send_word(32'hBEEF0004, a);
        wait_idle();
        n_checks++; if (rdy_low !== 4) $display("FAIL b2b_ready_low: got %0d want 4", rdy_low); else n_pass++;
        n_checks++; if (obs_s.size() !== 2) $display("FAIL b2b_nstrobe: got %0d want 2", obs_s.size()); else n_pass++;
        if (obs_s.size() == 2) begin
            n_checks++; if (obs_s[0] !== 32'h00000001) $display("FAIL b2b_strobe0: got %h want 00000001", obs_s[0]); else n_pass++;
            n_checks++; if (obs_d[0] !== 64'hCAFE0001_CAFE0002) $display("FAIL b2b_data0: got %h want cafe0001cafe0002", obs_d[0]); else n_pass++;
            n_checks++; if (obs_s[1] !== 32'h80000000) $display("FAIL b2b_strobe1: got %h want 80000000", obs_s[1]); else n_pass++;
            n_checks++; if (obs_d[1] !== 64'hBEEF0003_BEEF0004) $display("FAIL b2b_data1: got %h want beef0003beef0004", obs_d[1]); else n_pass++;
        end
        n_checks++; if (frames_written !== 16'd4) $display("FAIL b2b_count: got %0d want 4", frames_written); else n_pass++;
    endtask

    task automatic test_bad_index();
        int a;
        clear_mon();
        send_word(32'hFAB00020, a);
        send_word(32'h33333333, a);
        send_word(32'h44444444, a);
        idle(2);
        n_checks++; if (err !== 1'b1) $display("FAIL bad_err: got %b want 1", err); else n_pass++;
        n_checks++; if (obs_s.size() !== 0) $display("FAIL bad_strobe: got %0d strobes want 0", obs_s.size()); else n_pass++;
        n_checks++; if (FrameData !== 64'hBEEF0003_BEEF0004) $display("FAIL bad_data: got %h want beef0003beef0004", FrameData); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL bad_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (frames_written !== 16'd4) $display("FAIL bad_count: got %0d want 4", frames_written); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int a;
        clear_mon();
        send_word(32'hFAB00003, a);
        send_word(32'h77777777, a);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge CLK);
        #1 reset = 1'b0;
        n_checks++; if (FrameData !== 64'h0) $display("FAIL rmid_data: got %h want 0", FrameData); else n_pass++;
        n_checks++; if (FrameStrobe !== 32'h0) $display("FAIL rmid_strobe: got %h want 0", FrameStrobe); else n_pass++;
        n_checks++; if (err !== 1'b0) $display("FAIL rmid_err: got %b want 0", err); else n_pass++;
        n_checks++; if (frames_written !== 16'h0) $display("FAIL rmid_count: got %0d want 0", frames_written); else n_pass++;
        n_checks++; if (busy !== 1'b0 || in_ready !== 1'b1) $display("FAIL rmid_state: busy=%b ready=%b want 0/1", busy, in_ready); else n_pass++;
        idle(3);
        n_checks++; if (obs_s.size() !== 0) $display("FAIL rmid_nostrobe: got %0d strobes want 0", obs_s.size()); else n_pass++;
        send_word(32'hFAB00003, a);
        send_word(32'h01234567, a);
        send_word(32'h89ABCDEF, a);
        wait_idle();
        n_checks++; if (obs_s.size() !== 1) $display("FAIL rmid_after_n: got %0d want 1", obs_s.size()); else n_pass++;
        if (obs_s.size() > 0) begin
            n_checks++; if (obs_s[0] !== 32'h00000008) $display("FAIL rmid_after_strobe: got %h want 00000008", obs_s[0]); else n_pass++;
            n_checks++; if (obs_d[0] !== 64'h01234567_89ABCDEF) $display("FAIL rmid_after_data: got %h want 0123456789abcdef", obs_d[0]); else n_pass++;
        end
    endtask

    task automatic test_random();
        int a;
        logic [31:0] w;
        do_reset();
        stim_q.delete();
        exp_s.delete();
        exp_d.delete();
        m_data   = 64'h0;
        m_err    = 1'b0;
        m_frames = 0;
        for (int f = 0; f < 25; f++) begin
            if ($urandom_range(0, 4) == 0) begin
                do w = $urandom; while (w[31:16] == 16'hFAB0);
                stim_q.push_back(w);
            end else begin
                w = {16'hFAB0, 8'h00, 8'($urandom_range(0, 40))};
                if (f == 0) w[7:0] = 8'd31;
                if (f == 1) w[7:0] = 8'd255;
                stim_q.push_back(w);
                for (int r = 0; r < 2; r++) begin
                    w = $urandom;
                    if ($urandom_range(0, 5) == 0) w[31:16] = 16'hFAB0;
                    stim_q.push_back(w);
                end
            end
        end
        model_run();
        clear_mon();
        foreach (stim_q[i]) begin
            send_word(stim_q[i], a);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        wait_idle();
        idle(1);
        n_checks++; if (obs_s.size() !== exp_s.size()) $display("FAIL rnd_nstrobe: got %0d want %0d", obs_s.size(), exp_s.size()); else n_pass++;
        for (int i = 0; i < exp_s.size() && i < obs_s.size(); i++) begin
            n_checks++; if (obs_s[i] !== exp_s[i]) $display("FAIL rnd_strobe[%0d]: got %h want %h", i, obs_s[i], exp_s[i]); else n_pass++;
            n_checks++; if (obs_d[i] !== exp_d[i]) $display("FAIL rnd_data[%0d]: got %h want %h", i, obs_d[i], exp_d[i]); else n_pass++;
        end
        n_checks++; if (frames_written !== 16'(m_frames)) $display("FAIL rnd_count: got %0d want %0d", frames_written, m_frames); else n_pass++;
        n_checks++; if (err !== m_err) $display("FAIL rnd_err: got %b want %b", err, m_err); else n_pass++;
        n_checks++; if (FrameData !== m_data) $display("FAIL rnd_final_data: got %h want %h", FrameData, m_data); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rnd_busy: got %b want 0", busy); else n_pass++;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 32'h0;
        test_reset();
        test_basic();
        test_junk();
        test_stall();
        test_back_to_back();
        test_bad_index();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
